// File: rtl/id_exe_decode_stage_pkg.sv
// Shared decode constants: opcodes, ALU command encoding, branch types and
// instruction field positions. The exe_cmd values are shared with the ALU.
package id_exe_decode_stage_pkg;

    // Instruction field bit positions
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int DEST_HI   = 25;
    localparam int DEST_LO   = 21;
    localparam int SRC1_HI   = 20;
    localparam int SRC1_LO   = 16;
    localparam int SRC2_HI   = 15;
    localparam int SRC2_LO   = 11;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // Opcodes
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    // ALU execute commands
    localparam logic [3:0] EXE_ADD = 4'b0000;
    localparam logic [3:0] EXE_SUB = 4'b0010;
    localparam logic [3:0] EXE_AND = 4'b0100;
    localparam logic [3:0] EXE_OR  = 4'b0101;
    localparam logic [3:0] EXE_NOR = 4'b0110;
    localparam logic [3:0] EXE_XOR = 4'b0111;
    localparam logic [3:0] EXE_SLL = 4'b1000;
    localparam logic [3:0] EXE_SRA = 4'b1001;
    localparam logic [3:0] EXE_SRL = 4'b1010;

    // Branch types
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    // Register-register ops read their second source from the src2 field
    function automatic logic is_rtype(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_SLA, OP_SLL, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Store and conditional branches read their second source from the dest field
    function automatic logic src2_from_dest(input logic [5:0] op);
        case (op)
            OP_ST, OP_BNE, OP_BEZ: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_exe_decode_stage_control_unit.sv
// Combinational opcode decoder producing ALU command and stage controls.
module id_exe_decode_stage_control_unit
    import id_exe_decode_stage_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] exe_cmd,
    output logic       mem_r_en,
    output logic       mem_w_en,
    output logic       wb_en,
    output logic       is_imm,
    output logic [1:0] br_type,
    output logic       illegal
);

    // Opcode to control-word lookup; unknown opcodes flag illegal
    always_comb begin
        exe_cmd  = EXE_ADD;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        wb_en    = 1'b0;
        is_imm   = 1'b0;
        br_type  = BR_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_ADD:  begin exe_cmd = EXE_ADD; wb_en = 1'b1; end
            OP_SUB:  begin exe_cmd = EXE_SUB; wb_en = 1'b1; end
            OP_AND:  begin exe_cmd = EXE_AND; wb_en = 1'b1; end
            OP_OR:   begin exe_cmd = EXE_OR;  wb_en = 1'b1; end
            OP_NOR:  begin exe_cmd = EXE_NOR; wb_en = 1'b1; end
            OP_XOR:  begin exe_cmd = EXE_XOR; wb_en = 1'b1; end
            OP_SLA,
            OP_SLL:  begin exe_cmd = EXE_SLL; wb_en = 1'b1; end
            OP_SRA:  begin exe_cmd = EXE_SRA; wb_en = 1'b1; end
            OP_SRL:  begin exe_cmd = EXE_SRL; wb_en = 1'b1; end
            OP_ADDI: begin exe_cmd = EXE_ADD; wb_en = 1'b1; is_imm = 1'b1; end
            OP_SUBI: begin exe_cmd = EXE_SUB; wb_en = 1'b1; is_imm = 1'b1; end
            OP_LD:   begin mem_r_en = 1'b1; wb_en = 1'b1; is_imm = 1'b1; end
            OP_ST:   begin mem_w_en = 1'b1; is_imm = 1'b1; end
            OP_BEZ:  begin br_type = BR_BEZ; is_imm = 1'b1; end
            OP_BNE:  begin br_type = BR_BNE; is_imm = 1'b1; end
            OP_JMP:  begin br_type = BR_JMP; is_imm = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_exe_decode_stage.sv
// Instruction decode plus ID/EXE pipeline register with stall, flush and
// a saturating illegal-opcode counter.
module id_exe_decode_stage
    import id_exe_decode_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic [DATA_W-1:0] reg2_data,
    output logic [4:0]        src1,
    output logic [4:0]        src2,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] st_val,
    output logic [4:0]        dest,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en,
    output logic [1:0]        br_type,
    output logic [DATA_W-1:0] pc_out,
    output logic              out_valid,
    output logic [CNT_W-1:0]  illegal_cnt
);

    logic [5:0]        opcode;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext;

    logic [3:0] dec_exe_cmd;
    logic       dec_mem_r_en;
    logic       dec_mem_w_en;
    logic       dec_wb_en;
    logic       dec_is_imm;
    logic [1:0] dec_br_type;
    logic       dec_illegal;
    logic       load_ok;

    logic [3:0]        exe_cmd_q,   exe_cmd_d;
    logic [DATA_W-1:0] val1_q,      val1_d;
    logic [DATA_W-1:0] val2_q,      val2_d;
    logic [DATA_W-1:0] st_val_q,    st_val_d;
    logic [4:0]        dest_q,      dest_d;
    logic              mem_r_en_q,  mem_r_en_d;
    logic              mem_w_en_q,  mem_w_en_d;
    logic              wb_en_q,     wb_en_d;
    logic [1:0]        br_type_q,   br_type_d;
    logic [DATA_W-1:0] pc_q,        pc_d;
    logic              valid_q,     valid_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    assign opcode   = instruction[OPCODE_HI:OPCODE_LO];
    assign imm      = instruction[IMM_HI:IMM_LO];
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};

    id_exe_decode_stage_control_unit u_control_unit (
        .opcode   (opcode),
        .exe_cmd  (dec_exe_cmd),
        .mem_r_en (dec_mem_r_en),
        .mem_w_en (dec_mem_w_en),
        .wb_en    (dec_wb_en),
        .is_imm   (dec_is_imm),
        .br_type  (dec_br_type),
        .illegal  (dec_illegal)
    );

    // Source register addresses for the register file and hazard unit
    always_comb begin
        src1 = instruction[SRC1_HI:SRC1_LO];
        src2 = 5'd0;
        if (is_rtype(opcode)) begin
            src2 = instruction[SRC2_HI:SRC2_LO];
        end else if (src2_from_dest(opcode)) begin
            src2 = instruction[DEST_HI:DEST_LO];
        end
    end

    assign load_ok = instr_valid && !dec_illegal && (opcode != OP_NOP);

    // Next-state: flush bubbles, stall holds, otherwise decode or bubble
    always_comb begin
        exe_cmd_d  = exe_cmd_q;
        val1_d     = val1_q;
        val2_d     = val2_q;
        st_val_d   = st_val_q;
        dest_d     = dest_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        wb_en_d    = wb_en_q;
        br_type_d  = br_type_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        if (flush || !stall) begin
            exe_cmd_d  = 4'd0;
            val1_d     = '0;
            val2_d     = '0;
            st_val_d   = '0;
            dest_d     = 5'd0;
            mem_r_en_d = 1'b0;
            mem_w_en_d = 1'b0;
            wb_en_d    = 1'b0;
            br_type_d  = BR_NONE;
            pc_d       = '0;
            valid_d    = 1'b0;
            if (!flush && load_ok) begin
                exe_cmd_d  = dec_exe_cmd;
                val1_d     = reg1_data;
                val2_d     = dec_is_imm ? imm_sext : reg2_data;
                st_val_d   = (opcode == OP_ST) ? reg2_data : '0;
                dest_d     = instruction[DEST_HI:DEST_LO];
                mem_r_en_d = dec_mem_r_en;
                mem_w_en_d = dec_mem_w_en;
                wb_en_d    = dec_wb_en;
                br_type_d  = dec_br_type;
                pc_d       = pc_in;
                valid_d    = 1'b1;
            end
            // Only count illegal opcodes presented as valid and not flushed
            if (!flush && instr_valid && dec_illegal && (cnt_q != '1)) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ID/EXE pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_cmd_q  <= 4'd0;
            val1_q     <= '0;
            val2_q     <= '0;
            st_val_q   <= '0;
            dest_q     <= 5'd0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            wb_en_q    <= 1'b0;
            br_type_q  <= BR_NONE;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            exe_cmd_q  <= exe_cmd_d;
            val1_q     <= val1_d;
            val2_q     <= val2_d;
            st_val_q   <= st_val_d;
            dest_q     <= dest_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            wb_en_q    <= wb_en_d;
            br_type_q  <= br_type_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign exe_cmd     = exe_cmd_q;
    assign val1        = val1_q;
    assign val2        = val2_q;
    assign st_val      = st_val_q;
    assign dest        = dest_q;
    assign mem_r_en    = mem_r_en_q;
    assign mem_w_en    = mem_w_en_q;
    assign wb_en       = wb_en_q;
    assign br_type     = br_type_q;
    assign pc_out      = pc_q;
    assign out_valid   = valid_q;
    assign illegal_cnt = cnt_q;

endmodule
